// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor : gshare direction predictor, 2-bit counters, init sweep
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bht_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int HIST_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           if_pc,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_index,
   output logic                  ready,
   input  logic                  update_valid,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  update_pred_taken,
   input  logic                  update_taken,
   output logic                  misprediction
);

   localparam int C_ENTRIES = 1 << INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] C_LAST = INDEX_BITS'(C_ENTRIES - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   logic [INDEX_BITS-1:0] r_init_ptr;
   logic [1:0]            r_table [C_ENTRIES];

   logic                  w_run;
   logic                  w_train;
   logic [INDEX_BITS-1:0] w_hist_ext;
   logic [1:0]            w_cnt;
   logic                  w_unused_pc;

   // Outputs are held inactive during the reset cycle as well as the sweep.
   assign w_run   = (r_state == ST_RUN) && !rst;
   assign w_train = w_run && update_valid;

   generate
      if (HIST_BITS > 0) begin : g_hist
         logic [HIST_BITS-1:0] r_ghr;
         logic [HIST_BITS:0]   w_shift;

         assign w_shift    = {r_ghr, update_taken};
         assign w_hist_ext = INDEX_BITS'(r_ghr);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_ghr <= '0;
            end else if (w_train) begin
               r_ghr <= w_shift[HIST_BITS-1:0];
            end
         end
      end else begin : g_bimodal
         assign w_hist_ext = '0;
      end
   endgenerate

   assign pred_index    = if_pc[INDEX_BITS+1:2] ^ w_hist_ext;
   assign pred_taken    = w_run && r_table[pred_index][1];
   assign ready         = w_run;
   assign misprediction = w_train && (update_pred_taken != update_taken);
   assign w_unused_pc   = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};

   assign w_cnt = r_table[update_index];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_ptr <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_table[r_init_ptr] <= 2'b01;
               r_init_ptr          <= r_init_ptr + 1'b1;
               if (r_init_ptr == C_LAST) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Saturating update; no write when already at the rail.
               if (update_valid) begin
                  if (update_taken && (w_cnt != 2'b11)) begin
                     r_table[update_index] <= w_cnt + 2'b01;
                  end else if (!update_taken && (w_cnt != 2'b00)) begin
                     r_table[update_index] <= w_cnt - 2'b01;
                  end
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bht_predictor.sv
// ---------------------------------------------------------------------------
// tb_bht_predictor : directed self-checking bench (gshare and bimodal DUTs)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bht_predictor;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;

   // gshare instance (HIST_BITS=4)
   logic [31:0] if_pc;
   logic        pred_taken, ready, misprediction;
   logic [5:0]  pred_index;
   logic        update_valid, update_pred_taken, update_taken;
   logic [5:0]  update_index;

   // bimodal instance (HIST_BITS=0)
   logic [31:0] b_if_pc;
   logic        b_pred_taken, b_ready, b_misprediction;
   logic [5:0]  b_pred_index;
   logic        b_update_valid, b_update_pred_taken, b_update_taken;
   logic [5:0]  b_update_index;

   always #5 clk = ~clk;

   bht_predictor #(.INDEX_BITS(6), .HIST_BITS(4)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
      .pred_index(pred_index), .ready(ready), .update_valid(update_valid),
      .update_index(update_index), .update_pred_taken(update_pred_taken),
      .update_taken(update_taken), .misprediction(misprediction)
   );

   bht_predictor #(.INDEX_BITS(6), .HIST_BITS(0)) dut_bm (
      .clk(clk), .rst(rst), .if_pc(b_if_pc), .pred_taken(b_pred_taken),
      .pred_index(b_pred_index), .ready(b_ready), .update_valid(b_update_valid),
      .update_index(b_update_index), .update_pred_taken(b_update_pred_taken),
      .update_taken(b_update_taken), .misprediction(b_misprediction)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [5:0] idx, input logic p, input logic t);
      update_valid = v; update_index = idx; update_pred_taken = p; update_taken = t;
   endtask

   task automatic bupd(input logic v, input logic [5:0] idx, input logic p, input logic t);
      b_update_valid = v; b_update_index = idx; b_update_pred_taken = p; b_update_taken = t;
   endtask

   int low_cnt;

   initial begin
      rst = 1'b1;
      if_pc = 32'h0; b_if_pc = 32'h0;
      upd(0, 0, 0, 0);
      bupd(0, 0, 0, 0);

      // Reset cycle, then the 64-cycle sweep with a mismatching update mid-sweep.
      @(posedge clk); #1;
      #1 chk("ready_in_rst_cycle", ready, 0);
      rst = 1'b0;
      low_cnt = 0;
      for (int c = 0; c < 64; c++) begin
         if (c == 10) begin
            upd(1, 6'h05, 1, 0);
            bupd(1, 6'h05, 1, 0);
            b_if_pc = 32'h14;
            #1;
            chk("init_mispred", misprediction, 0);
            chk("init_mispred_bm", b_misprediction, 0);
            chk("init_pred_forced0", b_pred_taken, 0);
         end
         if (c == 11) begin
            upd(0, 0, 0, 0);
            bupd(0, 0, 0, 0);
         end
         #1;
         if (!ready) low_cnt++;
         tick();
      end
      chk("ready_low_cycles", low_cnt, 64);
      #1 chk("ready_rise", ready, 1);
      chk("ready_rise_bm", b_ready, 1);

      // Fresh table predicts not-taken.
      if_pc = 32'h0;  #1 chk("run_pred_pc0", pred_taken, 0);
      if_pc = 32'h40; #1 chk("run_pred_pc40", pred_taken, 0);
      if_pc = 32'hFC; #1 chk("run_pred_pcFC", pred_taken, 0);
      chk("run_idx_pcFC", pred_index, 6'h3F);

      // Misprediction strobe on the bimodal instance (index 0x20).
      bupd(1, 6'h20, 1, 0); #1 chk("mispred_valid", b_misprediction, 1);
      tick();
      bupd(0, 6'h20, 1, 0); #1 chk("mispred_novalid", b_misprediction, 0);
      tick();
      bupd(1, 6'h20, 1, 1); #1 chk("mispred_match", b_misprediction, 0);
      tick();

      // Saturation at index 0 (if_pc 0x100).
      b_if_pc = 32'h100;
      bupd(1, 6'h00, 0, 1);
      #1 chk("sat_idx", b_pred_index, 6'h00);
      chk("sat_c01_pred", b_pred_taken, 0);
      tick();
      bupd(1, 6'h00, 1, 1); #1 chk("sat_c10_pred", b_pred_taken, 1);
      tick();
      bupd(1, 6'h00, 1, 1); #1 chk("sat_c11_pred", b_pred_taken, 1);
      tick();
      bupd(1, 6'h00, 1, 0); #1 chk("sat_hold11_pred", b_pred_taken, 1);
      tick();
      bupd(1, 6'h00, 1, 0); #1 chk("sat_dn10_pred", b_pred_taken, 1);
      tick();
      bupd(0, 6'h00, 0, 0); #1 chk("sat_dn01_pred", b_pred_taken, 0);

      // Same-index collision at 0x05: old value this cycle, new value next.
      b_if_pc = 32'h14;
      bupd(1, 6'h05, 0, 1); #1 chk("coll_same_cycle", b_pred_taken, 0);
      chk("coll_idx", b_pred_index, 6'h05);
      tick();
      bupd(0, 6'h05, 0, 0); #1 chk("coll_next_cycle", b_pred_taken, 1);

      // History hash on the gshare instance: T, T, NT, T -> ghr 1101.
      if_pc = 32'h40;
      upd(1, 6'h30, 0, 1); #1 chk("hist_idx_g0", pred_index, 6'h10);
      tick();
      #1 chk("hist_idx_g1", pred_index, 6'h11);
      upd(1, 6'h30, 0, 1);
      tick();
      upd(1, 6'h30, 0, 0);
      tick();
      upd(1, 6'h30, 0, 1); #1 chk("hist_idx_preshift", pred_index, 6'h16);
      tick();
      upd(0, 0, 0, 0); #1 chk("hist_idx_1101", pred_index, 6'h1D);

      // Train 0x05 to 11: ghr 1101 -> 1011 -> 0111.
      upd(1, 6'h05, 0, 1); tick();
      upd(1, 6'h05, 1, 1); tick();
      upd(0, 0, 0, 0);
      if_pc = 32'h08;
      #1 chk("mid_idx", pred_index, 6'h05);
      chk("mid_trained", pred_taken, 1);

      // Reset mid-run with an in-flight mismatching update.
      rst = 1'b1;
      upd(1, 6'h05, 1, 0);
      #1 chk("rst_mispred", misprediction, 0);
      chk("rst_ready", ready, 0);
      tick();
      rst = 1'b0;
      upd(0, 0, 0, 0);
      low_cnt = 0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (!ready) low_cnt++;
         tick();
      end
      chk("resweep_low_cycles", low_cnt, 64);
      #1 chk("resweep_ready", ready, 1);
      if_pc = 32'h40; #1 chk("resweep_ghr0", pred_index, 6'h10);
      if_pc = 32'h14;
      upd(1, 6'h05, 0, 1); #1 chk("resweep_c05_01", pred_taken, 0);
      tick();
      upd(0, 0, 0, 0);
      if_pc = 32'h10; #1 chk("resweep_c05_10_idx", pred_index, 6'h05);
      chk("resweep_c05_10", pred_taken, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
Branch direction predictor feeding the branch-statistics counter and the fetch/EX stages of the RV32I pipeline.
- IF side: hashes the fetch PC with a global history register (gshare) and indexes a table of 2-bit saturating counters to produce a taken/not-taken prediction.
- EX side: trains the counters with resolved outcomes and raises the misprediction strobe that the statistics block and flush logic consume.
- After reset, an init sweep clears the table before predictions are trusted.

Parameters:
INDEX_BITS, 6, log2 of table entries (64 counters).
HIST_BITS, 4, global history length; 0 = pure bimodal; legal range 0..INDEX_BITS.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
if_pc  input  32  PC of the instruction in fetch.
pred_taken  output  1  predicted direction for if_pc (combinational).
pred_index  output  INDEX_BITS  table index used for if_pc; carried down the pipeline.
ready  output  1  high once the init sweep is complete.
update_valid  input  1  resolved conditional branch in EX this cycle.
update_index  input  INDEX_BITS  pred_index captured at prediction time.
update_pred_taken  input  1  prediction that was made for this branch.
update_taken  input  1  actual resolved direction.
misprediction  output  1  update_valid and direction mismatch (combinational).

Behaviour:
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Predict taken iff counter bit 1 is set.
- Index computation:
  - pred_index = if_pc[INDEX_BITS+1:2] XOR zero-extended ghr.
  - With HIST_BITS=0, pred_index = if_pc[INDEX_BITS+1:2].
- FSM states: INIT and RUN.
  - rst (any cycle, including mid-operation): next state INIT, init_ptr <= 0, ghr <= 0. An in-flight update in the reset cycle is discarded.
  - INIT: each cycle writes 01 to entry init_ptr and increments init_ptr. Once entry 2^INDEX_BITS-1 is written, next state is RUN.
  - RUN: normal operation; stays in RUN until rst.
- Reset values and INIT-state outputs:
  - ready = 0 throughout INIT, including the reset cycle; ready = 1 in RUN.
  - pred_taken forced to 0 while in INIT.
  - misprediction forced to 0 while in INIT.
  - Updates are ignored in INIT: no counter write, no ghr shift.
- Sweep timing: after rst is deasserted, ready rises after exactly 2^INDEX_BITS clocks.
- Training (RUN, update_valid=1):
  - Counter at update_index increments if update_taken, else decrements.
  - Saturates at 11 and 00; no wrap-around.
  - ghr <= {ghr[HIST_BITS-2:0], update_taken}; HIST_BITS=1 shifts a single bit.
  - ghr is non-speculative: it is updated only at resolution.
- misprediction = update_valid & (update_pred_taken != update_taken) in RUN. It is asserted in the same cycle as the update, with no register.
- Read/write ordering:
  - Table reads are combinational from the array.
  - A write in cycle N is visible on pred_taken in cycle N+1.
  - Same-cycle read and write to the same index returns the old value; there is no bypass.
  - pred_index in the same cycle uses the pre-shift ghr.
- update_index is trusted as-is; the block does not recompute it from PC.
- Implementation: table as flop array (2 x 2^INDEX_BITS bits); no memory macro.

Test Plan:
1. Reset sweep: INDEX_BITS=6; rst high 1 cycle, then low -> ready=0 for 64 cycles, 1 on cycle 65; in RUN, pred_taken=0 for if_pc 0x0, 0x40, 0xFC.
2. Saturation: HIST_BITS=0; three taken updates at index 0x00 (if_pc 0x100) -> counter 01→10→11→11, pred_taken=1 from the cycle after the first update; then two not-taken -> 11→10→01, pred_taken=0.
3. Misprediction strobe: RUN; update_valid=1, pred=1, taken=0 -> misprediction=1 that cycle. Same with update_valid=0 -> 0. Pred=taken=1 -> 0. During INIT with a mismatch -> 0.
4. History hash: HIST_BITS=4; outcomes taken, taken, not-taken, taken -> ghr=4'b1101; if_pc 0x40 -> pred_index = 0x10 XOR 0x0D = 0x1D.
5. Same-index collision: counter at 0x05 = 01; update taken at 0x05 while if_pc maps to 0x05 -> pred_taken=0 that cycle, 1 next cycle.
6. Reset mid-run: train 0x05 to 11, ghr nonzero, then assert rst with update_valid=1 in the same cycle -> update dropped, ready falls, sweep repeats; afterwards counter 0x05 = 01 and ghr = 0.
